// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants, FSM encoding and helpers for the convolution buffer arbiter
package conv_pkg;

    localparam int NREQ      = 3;
    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 16;
    localparam int LEN_W     = $clog2(MAX_BURST + 1);
    localparam int PTR_W     = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_BURST = 2'b01;
    localparam logic [1:0] S_DRAIN = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_BURST = S_BURST,
        ST_DRAIN = S_DRAIN
    } state_e;

    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (oh[j]) begin
                idx = idx | PTR_W'(j);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/conv_mem_arbiter_if.sv
// rtl/conv_mem_arbiter_if.sv - engine-side request/response bundle of the buffer read arbiter
interface conv_mem_arbiter_if;
    import conv_pkg::*;

    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*LEN_W-1:0]  req_len;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        rd_valid;
    logic [DATA_W-1:0]      rd_data;
    logic [NREQ-1:0]        done;

    modport master (
        output req, req_addr, req_len,
        input  gnt, rd_valid, rd_data, done
    );

    modport slave (
        input  req, req_addr, req_len,
        output gnt, rd_valid, rd_data, done
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, searching upward from ptr+1
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          valid
);

    // Rank 0 is the requester right after ptr; the lowest-ranked asserted one wins.
    always_comb begin
        int best;
        int rank;
        gnt   = '0;
        valid = 1'b0;
        best  = N;
        rank  = 0;
        for (int j = 0; j < N; j++) begin
            rank = (j + 2 * N - 1 - int'(ptr)) % N;
            if (req[j] && (rank < best)) begin
                best   = rank;
                gnt    = '0;
                gnt[j] = 1'b1;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_mem_arbiter.sv
// rtl/conv_mem_arbiter.sv - shares the buffer read port among the convolution engines with burst reads
module conv_mem_arbiter
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    conv_mem_arbiter_if.slave eng,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [1:0]        state_out
);

    state_e            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic              mem_en_q, mem_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              en_dly_q, en_dly_d;
    logic              busy_q, busy_d;
    logic [1:0]        state_out_q, state_out_d;

    logic [NREQ-1:0]   arb_gnt;
    logic              arb_valid;
    logic [ADDR_W-1:0] sel_addr;
    logic [LEN_W-1:0]  sel_len;
    logic [LEN_W-1:0]  clamp_len;

    rr_arbiter #(.N(NREQ), .PW(PTR_W)) u_arb (
        .req   (eng.req),
        .ptr   (ptr_q),
        .gnt   (arb_gnt),
        .valid (arb_valid)
    );

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (arb_gnt[j]) begin
                sel_addr = eng.req_addr[j*ADDR_W +: ADDR_W];
                sel_len  = eng.req_len[j*LEN_W +: LEN_W];
            end
        end
        clamp_len = (sel_len > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : sel_len;
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        done_d      = '0;
        mem_en_d    = mem_en_q;
        mem_addr_d  = mem_addr_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        ptr_d       = ptr_q;
        en_dly_d    = mem_en_q;
        busy_d      = (state_q != ST_IDLE);
        state_out_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    gnt_d      = arb_gnt;
                    ptr_d      = onehot_to_idx(arb_gnt);
                    len_d      = clamp_len;
                    mem_addr_d = sel_addr;
                    if (clamp_len == '0) begin
                        state_d  = ST_DRAIN;
                        mem_en_d = 1'b0;
                        cnt_d    = '0;
                        done_d   = arb_gnt;
                    end else begin
                        state_d  = ST_BURST;
                        mem_en_d = 1'b1;
                        cnt_d    = LEN_W'(1);
                    end
                end
            end
            ST_BURST: begin
                if (cnt_q < len_q) begin
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                    cnt_d      = cnt_q + LEN_W'(1);
                end else begin
                    mem_en_d = 1'b0;
                    state_d  = ST_DRAIN;
                    done_d   = gnt_q;
                end
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d  = ST_IDLE;
                gnt_d    = '0;
                mem_en_d = 1'b0;
            end
        endcase
    end

    // ptr resets to the last requester so requester 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            done_q      <= '0;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            ptr_q       <= PTR_W'(NREQ - 1);
            en_dly_q    <= 1'b0;
            busy_q      <= 1'b0;
            state_out_q <= S_IDLE;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            mem_en_q    <= mem_en_d;
            mem_addr_q  <= mem_addr_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            ptr_q       <= ptr_d;
            en_dly_q    <= en_dly_d;
            busy_q      <= busy_d;
            state_out_q <= state_out_d;
        end
    end

    assign eng.gnt      = gnt_q;
    assign eng.done     = done_q;
    assign eng.rd_valid = gnt_q & {NREQ{en_dly_q}};
    assign eng.rd_data  = mem_rdata;
    assign mem_en       = mem_en_q;
    assign mem_addr     = mem_addr_q;
    assign busy         = busy_q;
    assign state_out    = state_out_q;

endmodule
